gf180mcu_osu_sc_12t_pipe_buf: RTL
=================================

Name: gf180mcu_osu_sc_12t_pipe_buf

Overview:
- Parametrised successor to the single-bit combinational buffer cell: a WIDTH-bit, DEPTH-stage elastic pipelined buffer with a valid/ready handshake.
- Used as a retiming/repeater macro on long multi-bit routes between standard-cell blocks, where a plain buf cell cannot meet timing and back-pressure must be honoured.
- Lossless: every accepted word emerges exactly once, in order.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 2, number of register stages (1..16); no-stall latency A->Y in cycles.
- FULL_THROUGHPUT, 1, 1 = a stage may accept while its content leaves in the same cycle (ready chains combinationally backward); 0 = a stage accepts only when empty (ready registered per stage, half throughput).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- A  input  WIDTH  input data.
- A_VALID  input  1  A holds a word.
- A_READY  output  1  buffer accepts A this cycle.
- Y  output  WIDTH  output data (head stage content).
- Y_VALID  output  1  Y holds a word.
- Y_READY  input  1  consumer accepts Y this cycle.
- OCC  output  $clog2(DEPTH+1)  number of occupied stages.

Behaviour:
- Transfers: input transfer = A_VALID & A_READY at a rising CLK edge. Output transfer = Y_VALID & Y_READY at a rising CLK edge.
- Storage: stage i (0 = input side, DEPTH-1 = output side) holds V[i] and D[i]. Y = D[DEPTH-1]; Y_VALID = V[DEPTH-1].
- Advance rule with FULL_THROUGHPUT=1:
  - adv[DEPTH-1] = V[DEPTH-1] & Y_READY.
  - adv[i] = V[i] & (~V[i+1] | adv[i+1]).
  - A_READY = ~V[0] | adv[0].
- Advance rule with FULL_THROUGHPUT=0:
  - adv[i] = V[i] & ~V[i+1].
  - A_READY = ~V[0].
  - No combinational Y_READY->A_READY path.
- Stage update on each edge:
  - Stage i loads D[i-1] when adv[i-1]; stage 0 loads A on an input transfer.
  - V[i] is set when it loads and cleared when it advances without loading.
  - Simultaneous load and advance keeps V[i]=1 with new data.
- D of an empty stage is don't-care but must not change while V=0 and no load occurs (power).
- Latency: with Y_READY held high, a word accepted at edge k appears on Y after edge k+DEPTH-1, is valid during that cycle, and transfers at edge k+DEPTH.
- Throughput: one word/cycle with FULL_THROUGHPUT=1; one word per 2 cycles with FULL_THROUGHPUT=0 under continuous streaming.
- Stall: Y_READY low keeps Y and Y_VALID stable until the transfer. Upstream bubbles collapse, so DEPTH words are held before A_READY drops.
- Full (OCC=DEPTH):
  - A_READY = 0 if Y_READY=0.
  - With FULL_THROUGHPUT=1 and Y_READY=1, A_READY = 1 and OCC stays DEPTH.
- Empty (OCC=0): Y_VALID = 0; A_READY = 1.
- OCC update: OCC_next = OCC + in_xfer - out_xfer. Simultaneous in and out transfers leave OCC unchanged. OCC never exceeds DEPTH or wraps below 0.
- Protocol assertions: a producer must hold A stable while A_VALID=1 and A_READY=0. The bench asserts Y stability under stall.
- Reset: RST=1 at an edge clears every V[i] and sets OCC=0.
  - Resulting outputs: Y_VALID=0 and A_READY=1 (combinational from the cleared state). Y is don't-care; D registers need no reset.
  - Reset mid-stream drops all in-flight words. No input transfer is counted on a reset edge, even if A_VALID=1.
  - The first post-reset transfer occurs on the first edge with RST=0.
- Combinational paths: Y_READY->A_READY only when FULL_THROUGHPUT=1. No A->Y combinational path for any DEPTH.

Test Plan:
- Reset: DEPTH=2, WIDTH=8, drive A_VALID=1, A=8'hA5, assert RST for 2 edges -> Y_VALID=0, OCC=0, A_READY=1. Post-release, 8'hA5 appears on Y with Y_VALID=1 after 1 further edge with Y_READY=1.
- Streaming, FULL_THROUGHPUT=1, DEPTH=3: send 0x01..0x10 back-to-back with Y_READY=1 -> Y shows 0x01 after edge 2 (latency 3 to transfer), then one word per cycle, in order. OCC steady at 3, A_READY never drops.
- Back-pressure: DEPTH=4, Y_READY=0, A_VALID=1 for 6 cycles with 0x11..0x16 -> exactly 0x11..0x14 accepted, OCC=4, A_READY=0, Y=0x11 stable. Raise Y_READY -> 0x11..0x16 delivered with no loss or duplication.
- Simultaneous full in/out: FULL_THROUGHPUT=1, OCC=DEPTH=2, Y_READY=1, A_VALID=1 -> A_READY=1 in the same cycle, OCC remains 2.
- Half-throughput mode: FULL_THROUGHPUT=0, DEPTH=2, continuous input with Y_READY=1 -> 8 words transfer in 16±1 cycles. A_READY never depends combinationally on Y_READY (toggling Y_READY mid-cycle leaves A_READY unchanged).
- Mid-stream reset: OCC=3 with 0x21..0x23 in flight, pulse RST for 1 edge -> OCC=0, Y_VALID=0. None of 0x21..0x23 ever appear on Y.

Source files
------------

// File: rtl/gf180mcu_osu_sc_12t_pipe_buf.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_osu_sc_12t_pipe_buf
//  Purpose  : WIDTH-bit, DEPTH-stage elastic pipelined buffer with a
//             valid/ready handshake. Acts as a retiming/repeater macro on long
//             multi-bit routes. Every accepted word leaves exactly once and in
//             order.
//
//  Parameters
//    WIDTH            data width in bits (>= 1)
//    DEPTH            number of register stages (1..16), no-stall latency
//    FULL_THROUGHPUT  1: a stage may accept while its word leaves in the same
//                        cycle (ready ripples backward combinationally)
//                     0: a stage accepts only when empty (half throughput,
//                        no Y_READY -> A_READY combinational path)
//
//  Ports
//    CLK      in   rising-edge clock
//    RST      in   synchronous active-high reset
//    A        in   input data               A_VALID  in   A holds a word
//    A_READY  out  buffer accepts A now
//    Y        out  output data (head stage) Y_VALID  out  Y holds a word
//    Y_READY  in   consumer accepts Y now
//    OCC      out  number of occupied stages
//
//  Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_osu_sc_12t_pipe_buf #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 2,
    parameter bit FULL_THROUGHPUT = 1'b1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             A,
    input  logic                         A_VALID,
    output logic                         A_READY,
    output logic [WIDTH-1:0]             Y,
    output logic                         Y_VALID,
    input  logic                         Y_READY,
    output logic [$clog2(DEPTH+1)-1:0]   OCC
);

    localparam int c_occ_w = $clog2(DEPTH+1);

    // Stage 0 is the input side, stage DEPTH-1 drives Y.
    logic [DEPTH-1:0]   r_valid;
    logic [WIDTH-1:0]   r_data [DEPTH];
    logic [c_occ_w-1:0] r_occ;

    logic [DEPTH-1:0]   w_adv;      // stage i hands its word downstream
    logic [DEPTH-1:0]   w_load;     // stage i captures a new word
    logic [WIDTH-1:0]   w_src [DEPTH];
    logic               w_a_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;

    // ------------------------------------------------------------------------
    // Advance / ready generation
    // ------------------------------------------------------------------------
    generate
        if (FULL_THROUGHPUT) begin : g_full
            // Walk from the output stage toward the input. w_down_ok means
            // "the next stage downstream can take a word this cycle"; for the
            // head stage that is the consumer's ready. A stage frees up if it
            // is empty or its own word advances, so the ready ripples back.
            always_comb begin
                logic w_down_ok;
                w_adv     = '0;
                w_down_ok = Y_READY;
                for (int i = DEPTH-1; i >= 0; i--) begin
                    w_adv[i]  = r_valid[i] & w_down_ok;
                    w_down_ok = ~r_valid[i] | w_down_ok;
                end
                w_a_ready = w_down_ok;
            end
        end else begin : g_half
            // Each stage only looks at the registered valid of its successor,
            // so Y_READY reaches nothing but the head stage.
            // Bit k of w_dn_free: stage k is free to accept (k = DEPTH is the
            // consumer). Bit 0 doubles as A_READY.
            logic [DEPTH:0] w_dn_free;
            assign w_dn_free = {Y_READY, ~r_valid};
            assign w_adv     = r_valid & w_dn_free[DEPTH:1];
            assign w_a_ready = w_dn_free[0];
        end
    endgenerate

    assign w_in_xfer  = A_VALID & w_a_ready;
    assign w_out_xfer = r_valid[DEPTH-1] & Y_READY;

    // Load strobes and load sources: stage 0 takes A, stage i takes stage i-1.
    always_comb begin
        w_load    = '0;
        w_load[0] = w_in_xfer;
        w_src[0]  = A;
        for (int i = 1; i < DEPTH; i++) begin
            w_load[i] = w_adv[i-1];
            w_src[i]  = r_data[i-1];
        end
    end

    // ------------------------------------------------------------------------
    // Stage state
    // ------------------------------------------------------------------------
    // A stage stays valid if it reloads in the same cycle it advances.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= w_load[i] | (r_valid[i] & ~w_adv[i]);
            end
        end
    end

    // Data registers carry no reset and only toggle on a load, so an empty
    // stage holds its old contents and burns no switching power.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_load[i]) begin
                r_data[i] <= w_src[i];
            end
        end
    end

    // Occupancy counter. The handshake itself keeps it within 0..DEPTH:
    // a full buffer only accepts alongside an output transfer, an empty one
    // never presents Y_VALID.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + c_occ_w'(w_in_xfer) - c_occ_w'(w_out_xfer);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign A_READY = w_a_ready;
    assign Y       = r_data[DEPTH-1];
    assign Y_VALID = r_valid[DEPTH-1];
    assign OCC     = r_occ;

endmodule
`default_nettype wire
